// File: rtl/psg_bus_pkg.sv
// psg_bus_pkg: shared types and constants for the SharkPSG nibble-bus writer.
//   - psg_state_t : serialiser FSM states
//   - psg_cmd_t   : one queued register write {addr, data}
//   - register address constants of the PSG control block
//   - helpers mapping a strobe state to its bus nibble and successor state
package psg_bus_pkg;

   localparam int NYBBLE_W = 4;
   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 8;
   localparam int CMD_W    = ADDR_W + DATA_W;

   localparam logic [ADDR_W-1:0] REG_ENABLE = 4'h0;
   localparam logic [ADDR_W-1:0] REG_OCTAVE = 4'h1;
   localparam logic [ADDR_W-1:0] REG_PITCH0 = 4'h2;
   localparam logic [ADDR_W-1:0] REG_PITCH1 = 4'h3;
   localparam logic [ADDR_W-1:0] REG_PITCH2 = 4'h4;
   localparam logic [ADDR_W-1:0] REG_PITCH3 = 4'h5;
   localparam logic [ADDR_W-1:0] REG_VOL01  = 4'h6;
   localparam logic [ADDR_W-1:0] REG_VOL23  = 4'h7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DLO    = 3'd2,
      ST_DHI    = 3'd3,
      ST_COMMIT = 3'd4,
      ST_GAP    = 3'd5
   } psg_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } psg_cmd_t;

   // Bus image {address, data_high, da} driven while strobing in state st.
   function automatic logic [NYBBLE_W+1:0] nibble_for(input psg_state_t st, input psg_cmd_t c);
      logic [NYBBLE_W+1:0] r;
      r = {1'b0, 1'b0, 4'h0};
      case (st)
         ST_ADDR:           r = {1'b1, 1'b0, c.addr};
         ST_DLO:            r = {1'b0, 1'b0, c.data[3:0]};
         ST_DHI, ST_COMMIT: r = {1'b0, 1'b1, c.data[7:4]};
         default:           r = {1'b0, 1'b0, 4'h0};
      endcase
      return r;
   endfunction

   // Strobe state that follows st once its gap has elapsed (IDLE ends a command).
   function automatic psg_state_t next_strobe(input psg_state_t st);
      psg_state_t n;
      n = ST_IDLE;
      case (st)
         ST_ADDR: n = ST_DLO;
         ST_DLO:  n = ST_DHI;
         ST_DHI:  n = ST_COMMIT;
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/psg_bus_writer_if.sv
// psg_bus_writer_if: host write handshake plus PSG nibble-bus pins.
//   master : host side (drives wr_valid/wr_addr/wr_data, observes everything else)
//   slave  : psg_bus_writer side
//   wr_valid/wr_ready/wr_addr/wr_data : command handshake
//   strobe/address/data_high/da       : PSG control-block bus
//   busy                              : writer has work queued or in flight
interface psg_bus_writer_if;
   import psg_bus_pkg::*;

   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                strobe;
   logic                address;
   logic                data_high;
   logic [NYBBLE_W-1:0] da;
   logic                busy;

   modport master (
      output wr_valid, wr_addr, wr_data,
      input  wr_ready, strobe, address, data_high, da, busy
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      output wr_ready, strobe, address, data_high, da, busy
   );

endinterface

// File: rtl/psg_cmd_fifo.sv
// psg_cmd_fifo: synchronous command FIFO, synchronous active-high reset.
//   clk, rst      : clock, reset (empties the FIFO)
//   push, din     : write request and data (ignored when full)
//   pop, dout     : read request and head entry (ignored when empty)
//   full, empty   : status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module psg_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                      (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign dout      = mem[rd_ptr_r[IDX_W-1:0]];

   // Pointer update; wraps naturally modulo 2*DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem[wr_ptr_r[IDX_W-1:0]] <= din;
   end

endmodule

// File: rtl/psg_bus_writer.sv
// psg_bus_writer: queues host register writes and serialises each one onto
// the SharkPSG 4-bit nibble bus as ADDR, DLO, DHI, COMMIT strobes, each
// followed by GAP_CYCLES strobe-low cycles.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   ena  : global enable; low freezes the serialiser and blocks push/pop
//   bus  : psg_bus_writer_if.slave (wr_valid/wr_ready/wr_addr/wr_data,
//          strobe/address/data_high/da, busy)
// Optional build macro PSG_ADDR_CACHE_EN: remembers the last address sent
// and skips the ADDR strobe when the next command targets the same register.
module psg_bus_writer
   import psg_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   psg_bus_writer_if.slave      bus
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   psg_cmd_t            fifo_din_s;
   psg_cmd_t            fifo_dout_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic                push_s;
   logic                pop_s;
   logic                gap_done_s;

   psg_state_t          state_r;
   psg_state_t          after_gap_r;
   psg_cmd_t            cmd_r;
   logic [GAP_W-1:0]    gap_cnt_r;
   logic                strobe_r;
   logic                address_r;
   logic                data_high_r;
   logic [NYBBLE_W-1:0] da_r;

`ifdef PSG_ADDR_CACHE_EN
   logic [ADDR_W-1:0]   last_addr_r;
   logic                cache_valid_r;
`endif

   assign bus.wr_ready = ena & ~fifo_full_s & ~rst;
   assign push_s       = bus.wr_valid & bus.wr_ready;
   assign fifo_din_s   = '{addr: bus.wr_addr, data: bus.wr_data};
   assign gap_done_s   = (gap_cnt_r == GAP_LAST);

   // A new command starts from IDLE, or straight out of COMMIT's final gap
   // cycle so back-to-back commands leave no idle cycle between them.
   assign pop_s = ena & ~fifo_empty_s &
                  ((state_r == ST_IDLE) |
                   ((state_r == ST_GAP) & gap_done_s & (after_gap_r == ST_IDLE)));

   psg_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Serialiser FSM; bus outputs are loaded on the edge that enters a state,
   // so the strobe is visible during the cycle the FSM sits in that state.
   // With ena low nothing changes, so the strobe state is replayed later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         after_gap_r <= ST_IDLE;
         cmd_r       <= '0;
         gap_cnt_r   <= {GAP_W{1'b0}};
         strobe_r    <= 1'b0;
         address_r   <= 1'b0;
         data_high_r <= 1'b0;
         da_r        <= 4'h0;
`ifdef PSG_ADDR_CACHE_EN
         last_addr_r   <= 4'h0;
         cache_valid_r <= 1'b0;
`endif
      end else if (ena) begin
         if (pop_s) begin
            cmd_r     <= fifo_dout_s;
            gap_cnt_r <= {GAP_W{1'b0}};
            strobe_r  <= 1'b1;
`ifdef PSG_ADDR_CACHE_EN
            if (cache_valid_r && (fifo_dout_s.addr == last_addr_r)) begin
               state_r <= ST_DLO;
               {address_r, data_high_r, da_r} <= nibble_for(ST_DLO, fifo_dout_s);
            end else begin
               state_r       <= ST_ADDR;
               {address_r, data_high_r, da_r} <= nibble_for(ST_ADDR, fifo_dout_s);
               last_addr_r   <= fifo_dout_s.addr;
               cache_valid_r <= 1'b1;
            end
`else
            state_r <= ST_ADDR;
            {address_r, data_high_r, da_r} <= nibble_for(ST_ADDR, fifo_dout_s);
`endif
         end else begin
            case (state_r)
               ST_IDLE: begin
                  strobe_r <= 1'b0;
               end
               ST_ADDR, ST_DLO, ST_DHI, ST_COMMIT: begin
                  strobe_r    <= 1'b0;
                  state_r     <= ST_GAP;
                  after_gap_r <= next_strobe(state_r);
                  gap_cnt_r   <= {GAP_W{1'b0}};
               end
               ST_GAP: begin
                  if (gap_done_s) begin
                     gap_cnt_r <= {GAP_W{1'b0}};
                     if (after_gap_r == ST_IDLE) begin
                        state_r <= ST_IDLE;
                     end else begin
                        state_r  <= after_gap_r;
                        strobe_r <= 1'b1;
                        {address_r, data_high_r, da_r} <= nibble_for(after_gap_r, cmd_r);
                     end
                  end else begin
                     gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  strobe_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // strobe_r is held through an ena-low stretch so the interrupted strobe
   // can be replayed; qualifying it with ena keeps the pin low meanwhile.
   assign bus.strobe    = strobe_r & ena;
   assign bus.address   = address_r;
   assign bus.data_high = data_high_r;
   assign bus.da        = da_r;
   assign bus.busy      = ~fifo_empty_s | (state_r != ST_IDLE);

endmodule

// File: tb/tb_psg_bus_writer.sv
// tb_psg_bus_writer: directed test of psg_bus_writer (FIFO_DEPTH=4,
// GAP_CYCLES=1) against a receiver model of the PSG control block.
// Expectations for PSG_ADDR_CACHE_EN builds are selected by the same macro.
module tb_psg_bus_writer;

   logic clk = 1'b0;
   logic rst;
   logic ena;

   always #5 clk = ~clk;

   psg_bus_writer_if bus();

   psg_bus_writer #(
      .FIFO_DEPTH (4),
      .GAP_CYCLES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Receiver model: ADDR latches the target, DLO fills the low nibble, a
   // data_high strobe writes the previously held byte then updates the high nibble.
   logic [7:0] rx_reg [8];
   logic [3:0] rx_addr;
   logic [7:0] rx_hold;
   int         ns = 0;
   logic [3:0] log_da   [256];
   logic       log_addr [256];
   logic       log_dh   [256];
   int         log_cyc  [256];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.strobe === 1'b1) begin
         if (ns < 256) begin
            log_da[ns]   = bus.da;
            log_addr[ns] = bus.address;
            log_dh[ns]   = bus.data_high;
            log_cyc[ns]  = cyc;
         end
         ns = ns + 1;
         if (bus.address) begin
            rx_addr = bus.da;
         end else if (bus.data_high) begin
            if (!rx_addr[3]) rx_reg[rx_addr[2:0]] = rx_hold;
            rx_hold[7:4] = bus.da;
         end else begin
            rx_hold[3:0] = bus.da;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the FIFO able to accept; returns one negedge later.
   task automatic push_one(input logic [3:0] a, input logic [7:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      #1;
      chk("push_ready", bus.wr_ready, 1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (bus.busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle"}, bus.busy, 0);
   endtask

   // Starting at the negedge after the pop edge, checks the 8-cycle pattern.
   task automatic check_cmd_seq(input string tag, input logic [3:0] a, input logic [7:0] d);
      logic [3:0] exp_da;
      for (int p = 0; p < 8; p++) begin
         case (p / 2)
            0:       exp_da = a;
            1:       exp_da = d[3:0];
            default: exp_da = d[7:4];
         endcase
         chk({tag, "_strobe"}, bus.strobe, (p % 2 == 0) ? 1 : 0);
         chk({tag, "_address"}, bus.address, (p / 2 == 0) ? 1 : 0);
         chk({tag, "_data_high"}, bus.data_high, (p / 2 >= 2) ? 1 : 0);
         chk({tag, "_da"}, bus.da, exp_da);
         chk({tag, "_busy"}, bus.busy, 1);
         @(negedge clk);
      end
   endtask

   logic [3:0] b_addr [6];
   logic [7:0] b_data [6];
   logic [7:0] exp_regs [8];

   initial begin
      int base;
      int acc;
      int k;
      int bad;
      int n_a;
      logic ready_now;
      logic dropped;
      logic found;
      logic [3:0] exp_da;

      for (int i = 0; i < 8; i++) rx_reg[i] = 8'h00;
      rx_addr = 4'h0;
      rx_hold = 8'h00;
      b_addr = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      b_data = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      exp_regs = '{8'h00, 8'h03, 8'h12, 8'h44, 8'h33, 8'h78, 8'h9A, 8'hC3};

      bus.wr_valid = 1'b0;
      bus.wr_addr  = 4'h0;
      bus.wr_data  = 8'h00;
      rst = 1'b1;
      ena = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_strobe", bus.strobe, 0);
      chk("rst_address", bus.address, 0);
      chk("rst_data_high", bus.data_high, 0);
      chk("rst_da", bus.da, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready_in_reset", bus.wr_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", bus.wr_ready, 1);

      // Single write to PITCH0
      base = ns;
      push_one(4'h2, 8'hA5);
      chk("t1_idle_strobe", bus.strobe, 0);
      chk("t1_busy_queued", bus.busy, 1);
      @(negedge clk);
      check_cmd_seq("t1", 4'h2, 8'hA5);
      chk("t1_busy_fall", bus.busy, 0);
      chk("t1_strobe_count", ns - base, 4);
      chk("t1_pitch0", rx_reg[2], 8'hA5);

      // Back-to-back burst of 6 into a depth-4 FIFO
      base = ns;
      acc = 0;
      k = 0;
      dropped = 1'b0;
      while (acc < 6 && k < 60) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = b_addr[acc];
         bus.wr_data  = b_data[acc];
         #1;
         ready_now = bus.wr_ready;
         if (!ready_now && !dropped) begin
            dropped = 1'b1;
            chk("t2_ready_drop_accepts", acc, 5);
         end
         @(negedge clk);
         if (ready_now) acc++;
         k++;
      end
      bus.wr_valid = 1'b0;
      chk("t2_all_accepted", acc, 6);
      chk("t2_ready_dropped", dropped, 1);
      wait_idle("t2", 200);
      chk("t2_strobe_count", ns - base, 24);
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 4; j++) begin
            case (j)
               0:       exp_da = b_addr[i];
               1:       exp_da = b_data[i][3:0];
               default: exp_da = b_data[i][7:4];
            endcase
            chk("t2_order_da", log_da[base + 4*i + j], exp_da);
         end
         chk("t2_order_addrflag", log_addr[base + 4*i], 1);
      end
      bad = 0;
      for (int i = 1; i < 24; i++) begin
         if (log_cyc[base + i] - log_cyc[base + i - 1] != 2) bad++;
      end
      chk("t2_spacing", bad, 0);

      // ena low for 3 cycles during a DHI strobe
      base = ns;
      push_one(4'h7, 8'hC3);
      k = 0;
      found = 1'b0;
      while (!found && k < 20) begin
         if (bus.strobe === 1'b1 && bus.data_high === 1'b1) found = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      chk("t3_dhi_found", found, 1);
      ena = 1'b0;
      #1;
      chk("t3_ena_low_strobe", bus.strobe, 0);
      chk("t3_ena_low_ready", bus.wr_ready, 0);
      chk("t3_ena_low_busy", bus.busy, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_hold_strobe", bus.strobe, 0);
         chk("t3_hold_data_high", bus.data_high, 1);
         chk("t3_hold_da", bus.da, 4'hC);
      end
      ena = 1'b1;
      #1;
      chk("t3_replay_strobe", bus.strobe, 1);
      chk("t3_replay_data_high", bus.data_high, 1);
      chk("t3_replay_da", bus.da, 4'hC);
      wait_idle("t3", 40);
      chk("t3_strobe_count", ns - base, 4);
      chk("t3_vol23", rx_reg[7], 8'hC3);

      // Reset in the middle of a DLO strobe drops all queued work
      push_one(4'h0, 8'h5A);
      push_one(4'h1, 8'h66);
      push_one(4'h2, 8'h77);
      k = 0;
      found = 1'b0;
      while (!found && k < 10) begin
         if (bus.strobe === 1'b1 && bus.address === 1'b0 && bus.data_high === 1'b0) found = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      chk("t4_dlo_found", found, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t4_strobe", bus.strobe, 0);
      chk("t4_da", bus.da, 0);
      chk("t4_address", bus.address, 0);
      chk("t4_data_high", bus.data_high, 0);
      chk("t4_busy", bus.busy, 0);
      chk("t4_ready", bus.wr_ready, 1);
      base = ns;
      repeat (20) @(negedge clk);
      chk("t4_no_strobes", ns - base, 0);
      chk("t4_reg0_unchanged", rx_reg[0], 8'h00);
      chk("t4_reg1_unchanged", rx_reg[1], 8'h03);

      // Repeated address: ADDR skipped only when the cache is built in
      base = ns;
      push_one(4'h3, 8'h11);
      push_one(4'h3, 8'h22);
      push_one(4'h4, 8'h33);
      wait_idle("t5", 100);
      n_a = 0;
      for (int i = base; i < ns; i++) if (log_addr[i]) n_a++;
`ifdef PSG_ADDR_CACHE_EN
      chk("t5_strobe_count", ns - base, 11);
      chk("t5_addr_strobes", n_a, 2);
      chk("t5_second_starts_dlo", log_addr[base + 4], 0);
`else
      chk("t5_strobe_count", ns - base, 12);
      chk("t5_addr_strobes", n_a, 3);
      chk("t5_second_starts_addr", log_addr[base + 4], 1);
`endif
      chk("t5_reg3", rx_reg[3], 8'h22);
      chk("t5_reg4", rx_reg[4], 8'h33);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      base = ns;
      push_one(4'h3, 8'h44);
      wait_idle("t5b", 40);
      chk("t5b_strobe_count", ns - base, 4);
      chk("t5b_addr_flag", log_addr[base], 1);
      chk("t5b_addr_da", log_da[base], 4'h3);
      chk("t5b_reg3", rx_reg[3], 8'h44);

      // Out-of-range address: full sequence, receiver registers untouched
      base = ns;
      push_one(4'hF, 8'hFF);
      wait_idle("t6", 40);
      chk("t6_strobe_count", ns - base, 4);
      chk("t6_addr_flag", log_addr[base], 1);
      chk("t6_addr_da", log_da[base], 4'hF);
      chk("t6_commit_dh", log_dh[base + 3], 1);
      chk("t6_commit_da", log_da[base + 3], 4'hF);
      for (int i = 0; i < 8; i++) begin
         chk("t6_regs", rx_reg[i], exp_regs[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/psg_bus_writer.md
Name: psg_bus_writer

Overview:
- Host-side driver for the SharkPSG 4-bit nibble control bus.
- Accepts whole register writes (4-bit address, 8-bit data) over a valid/ready interface and buffers them in a small FIFO.
- Serialises each write into the strobe/address/data_high/da nibble sequence that the PSG control block decodes.
- Sits between a host (MCU bridge, sequencer ROM) and the PSG control-block bus pins.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- GAP_CYCLES, 1, strobe-low cycles after every strobe cycle; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; low pauses the block
- wr_valid  in  1  host presents a write command
- wr_ready  out  1  FIFO can accept; equals ena & !full & !rst
- wr_addr  in  4  target register address, 0x0-0xF
- wr_data  in  8  register value
- strobe  out  1  nibble strobe, one-cycle pulses
- address  out  1  high when da carries an address nibble
- data_high  out  1  high when da carries the high data nibble
- da  out  4  nibble bus
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - strobe, address, data_high, da and busy are 0.
  - FIFO is emptied; FSM goes to IDLE; gap counter is cleared.
  - rst has priority over every other event.
- Command accept: a push happens on any clk edge where wr_valid & wr_ready. A push is allowed on the same edge as a pop.
- All bus outputs are registered.
- FSM states: IDLE, ADDR, DLO, DHI, COMMIT, GAP.
- IDLE: when the FIFO is non-empty, pop the head and latch {addr, data}.
  - Next state is ADDR.
  - First strobe appears in the cycle after the pop edge. With an empty FIFO, a push on edge N gives a strobe in cycle N+2.
- ADDR: strobe=1, address=1, data_high=0, da=addr.
- DLO: strobe=1, address=0, data_high=0, da=data[3:0].
- DHI: strobe=1, address=0, data_high=1, da=data[7:4].
- COMMIT: repeats DHI exactly (strobe=1, data_high=1, da=data[7:4]).
  - The receiver writes the target register from its previously held data byte, so the fourth strobe is required to commit the complete byte.
  - Rewriting the high nibble is idempotent.
- GAP: entered after every strobe state.
  - strobe=0; address, data_high and da hold their values.
  - Lasts GAP_CYCLES cycles, then moves to the next strobe state.
  - After COMMIT's gap, go to IDLE. If the FIFO is non-empty at that point, pop on the same edge, so there is no extra idle cycle.
- Throughput: one command per 4*(1+GAP_CYCLES) cycles; 8 cycles at the defaults.
- Addresses 0x8-0xF are emitted unchanged; the receiver ignores them.
- ena low:
  - FSM and gap counter freeze.
  - strobe is forced to 0; address, data_high and da hold.
  - No push and no pop.
  - On ena rising, the interrupted strobe state is re-emitted in full.
- FIFO full: wr_ready=0; wr_valid is ignored and no data is lost.
- FIFO empty in IDLE: outputs hold their last values with strobe=0; busy=0.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full when the MSBs differ and the low bits are equal.

Optional Feature:
- Macro: PSG_ADDR_CACHE_EN.
- Defined:
  - Keep last_addr plus a valid bit; valid is cleared on rst.
  - In IDLE, if the popped addr equals last_addr and valid=1, skip ADDR and its gap; go straight to DLO.
  - Set last_addr and valid whenever an ADDR strobe is emitted.
  - Per-command latency at defaults drops to 6 cycles on a hit.
- Undefined: every command emits the ADDR nibble; no cache logic is present.

Decomposition:
- Package psg_bus_pkg:
  - FSM state enum.
  - NYBBLE_W=4, ADDR_W=4, DATA_W=8.
  - Register address constants: REG_ENABLE=0, REG_OCTAVE=1, REG_PITCH0..3=2..5, REG_VOL01=6, REG_VOL23=7.
- One sub-module, psg_cmd_fifo: synchronous FIFO of width ADDR_W+DATA_W with push/pop/full/empty and synchronous active-high reset.

Test Plan:
- Single write addr=0x2, data=0xA5, GAP=1: strobe pulses every 2nd cycle. Nibbles are ADDR da=2, DLO da=5, DHI da=A, COMMIT da=A. A receiver model ends with pitch0=0xA5. busy falls 8 cycles after the pop.
- Back-to-back bursts: push 6 commands into a depth-4 FIFO. wr_ready drops after 5 accepts (4 stored plus 1 popped). All 6 commands emerge in order with no idle cycle between them.
- ena dropped for 3 cycles during a DHI strobe: no strobe while ena is low. DHI is re-emitted after ena returns. The receiver's final value is correct.
- rst asserted mid-DLO: the next cycle has strobe=0, da=0, busy=0 and wr_ready=1. The queued commands are gone.
- PSG_ADDR_CACHE_EN defined: writes (3,0x11), (3,0x22), (4,0x33) produce 4, 3 and 4 strobes respectively. After a reset, a write to address 3 again emits ADDR.
- Write to addr=0xF, data=0xFF: the full 4-strobe sequence is emitted. The receiver model registers 0-7 are unchanged.
